// File: rtl/seg_pattern_reader_if.sv
// Signal bundle between the two seven-segment read-back buses and the pattern reader.
// master drives the segment buses; slave is the reader that returns the decoded results.
interface seg_pattern_reader_if #(
  parameter int unsigned ERR_W = 8
);
  logic [8:0]       seg_led_1;
  logic [8:0]       seg_led_2;
  logic [3:0]       digit_1;
  logic [3:0]       digit_2;
  logic             valid_1;
  logic             valid_2;
  logic             dp_1;
  logic             dp_2;
  logic             err_1;
  logic             err_2;
  logic [6:0]       value;
  logic             upd;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output seg_led_1, seg_led_2,
    input  digit_1, digit_2, valid_1, valid_2, dp_1, dp_2, err_1, err_2, value, upd, err_cnt
  );

  modport slave (
    input  seg_led_1, seg_led_2,
    output digit_1, digit_2, valid_1, valid_2, dp_1, dp_2, err_1, err_2, value, upd, err_cnt
  );
endinterface

// File: rtl/seg_pattern_reader.sv
// Reads back two 9-bit seven-segment buses, filters each for stability and decodes the
// settled pattern to BCD, DP and validity; also combines the digits and counts illegal codes.
module seg_pattern_reader #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned ERR_W         = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seg_pattern_reader_if.slave  bus_io
);

  localparam int unsigned     CntW   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);
  localparam int unsigned     SumW   = ERR_W + 1;
  localparam logic [ERR_W-1:0] ErrMax = {ERR_W{1'b1}};

  typedef struct packed {
    logic [3:0] digit;
    logic       valid;
    logic       err;
    logic       dp;
  } dec_t;

  localparam dec_t RstDec = '{digit: 4'hF, valid: 1'b0, err: 1'b0, dp: 1'b0};

  function automatic dec_t decode(input logic [8:0] pat);
    dec_t d;
    d.dp    = pat[7];
    d.digit = 4'hF;
    d.valid = 1'b0;
    d.err   = 1'b0;
    // DIG high means the digit is switched off, so it reads back as blank.
    if (!pat[8]) begin
      d.valid = 1'b1;
      case (pat[6:0])
        7'h3F:   d.digit = 4'd0;
        7'h06:   d.digit = 4'd1;
        7'h5B:   d.digit = 4'd2;
        7'h4F:   d.digit = 4'd3;
        7'h66:   d.digit = 4'd4;
        7'h6D:   d.digit = 4'd5;
        7'h7D:   d.digit = 4'd6;
        7'h07:   d.digit = 4'd7;
        7'h7F:   d.digit = 4'd8;
        7'h6F:   d.digit = 4'd9;
        7'h00:   d.valid = 1'b0;
        default: begin
          d.digit = 4'hE;
          d.valid = 1'b0;
          d.err   = 1'b1;
        end
      endcase
    end
    return d;
  endfunction

  logic [1:0][8:0]      seg_in;
  logic [1:0][8:0]      in_q;
  logic [1:0][8:0]      cand_q, cand_d;
  logic [1:0][CntW-1:0] cnt_q, cnt_d;
  logic [1:0][8:0]      acc_q, acc_d;
  logic [1:0]           accept;
  logic [1:0]           err_inc;
  dec_t [1:0]           dec_q, dec_d;
  logic [6:0]           value_q, value_d;
  logic                 upd_q, upd_d;
  logic [ERR_W-1:0]     err_cnt_q, err_cnt_d;
  logic [SumW-1:0]      err_sum;

  assign seg_in[0] = bus_io.seg_led_1;
  assign seg_in[1] = bus_io.seg_led_2;

  // Stability filter and acceptance, identical and independent per channel.
  always_comb begin
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    accept  = '0;
    err_inc = '0;
    dec_d   = dec_q;
    for (int ch = 0; ch < 2; ch++) begin
      if (in_q[ch] != cand_q[ch]) begin
        cand_d[ch] = in_q[ch];
        cnt_d[ch]  = '0;
      end else if (cnt_q[ch] != CntMax) begin
        cnt_d[ch] = cnt_q[ch] + CntW'(1);
      end
      if ((cnt_q[ch] == CntMax) && (cand_q[ch] != acc_q[ch])) begin
        accept[ch] = 1'b1;
        acc_d[ch]  = cand_q[ch];
      end
      dec_d[ch]   = decode(acc_d[ch]);
      err_inc[ch] = accept[ch] & dec_d[ch].err;
    end
  end

  // Combined value and counters are derived from the post-update decode.
  always_comb begin
    value_d = '0;
    if (dec_d[0].valid && dec_d[1].valid) begin
      value_d = 7'(dec_d[0].digit) * 7'd10 + 7'(dec_d[1].digit);
    end
    upd_d   = |accept;
    err_sum = {1'b0, err_cnt_q} + SumW'(err_inc[0]) + SumW'(err_inc[1]);
    if (err_sum > {1'b0, ErrMax}) begin
      err_cnt_d = ErrMax;
    end else begin
      err_cnt_d = err_sum[ERR_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_q      <= '0;
      cand_q    <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      dec_q     <= {RstDec, RstDec};
      value_q   <= '0;
      upd_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      in_q      <= seg_in;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      dec_q     <= dec_d;
      value_q   <= value_d;
      upd_q     <= upd_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus_io.digit_1 = dec_q[0].digit;
  assign bus_io.digit_2 = dec_q[1].digit;
  assign bus_io.valid_1 = dec_q[0].valid;
  assign bus_io.valid_2 = dec_q[1].valid;
  assign bus_io.dp_1    = dec_q[0].dp;
  assign bus_io.dp_2    = dec_q[1].dp;
  assign bus_io.err_1   = dec_q[0].err;
  assign bus_io.err_2   = dec_q[1].err;
  assign bus_io.value   = value_q;
  assign bus_io.upd     = upd_q;
  assign bus_io.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_seg_pattern_reader.sv
// Directed bench for seg_pattern_reader: a sample-history reference model checked every cycle,
// plus hand-computed expectations at the key edges of each scenario.
module tb_seg_pattern_reader;

  localparam int unsigned STABLE = 4;
  localparam int unsigned EW     = 2;
  localparam int          EMAX   = (1 << EW) - 1;
  localparam int          HL     = STABLE + 2;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  seg_pattern_reader_if #(.ERR_W(EW)) bus ();

  seg_pattern_reader #(
    .STABLE_CYCLES (STABLE),
    .ERR_W         (EW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a pattern is taken once it filled the S sample slots ending two edges ago.
  logic [8:0] lut [10] = '{9'h03F, 9'h006, 9'h05B, 9'h04F, 9'h066,
                           9'h06D, 9'h07D, 9'h007, 9'h07F, 9'h06F};

  function automatic void mdec(input logic [8:0] p, output logic [3:0] d, output logic v,
                               output logic e);
    d = 4'hF; v = 1'b0; e = 1'b0;
    if (!p[8] && p[6:0] != 7'h00) begin
      d = 4'hE; e = 1'b1;
      for (int i = 0; i < 10; i++) begin
        if (lut[i][6:0] == p[6:0]) begin
          d = 4'(i); v = 1'b1; e = 1'b0;
        end
      end
    end
  endfunction

  function automatic bit ready(input logic [8:0] q[$], input logic [8:0] acc,
                               output logic [8:0] p);
    bit same = 1'b1;
    int n = q.size();
    p = q[n-3];
    for (int k = 2; k <= STABLE + 1; k++) if (q[n-1-k] != p) same = 1'b0;
    return same && (p != acc);
  endfunction

  logic [8:0] h1[$], h2[$];
  logic [8:0] m_acc1, m_acc2, p1, p2;
  logic [3:0] m_d1, m_d2;
  logic       m_v1, m_v2, m_e1, m_e2, m_upd;
  int         m_val, m_cnt;
  bit         live = 1'b0;

  initial forever begin
    bit a1, a2;
    @(posedge clk);
    if (!rst_n) begin
      live = 1'b1;
      h1 = {}; h2 = {};
      for (int i = 0; i < HL; i++) begin h1.push_back(9'h0); h2.push_back(9'h0); end
      m_acc1 = 9'h0; m_acc2 = 9'h0;
      m_d1 = 4'hF; m_d2 = 4'hF; m_v1 = 0; m_v2 = 0; m_e1 = 0; m_e2 = 0;
      m_val = 0; m_upd = 0; m_cnt = 0;
    end else if (live) begin
      h1.push_back(bus.seg_led_1); void'(h1.pop_front());
      h2.push_back(bus.seg_led_2); void'(h2.pop_front());
      a1 = ready(h1, m_acc1, p1);
      a2 = ready(h2, m_acc2, p2);
      if (a1) m_acc1 = p1;
      if (a2) m_acc2 = p2;
      mdec(m_acc1, m_d1, m_v1, m_e1);
      mdec(m_acc2, m_d2, m_v2, m_e2);
      m_upd = a1 | a2;
      m_cnt = m_cnt + int'(a1 && m_e1) + int'(a2 && m_e2);
      if (m_cnt > EMAX) m_cnt = EMAX;
      m_val = (m_v1 && m_v2) ? m_d1 * 10 + m_d2 : 0;
    end
    #1;
    if (live) begin
      check("m_digit_1", bus.digit_1, m_d1);
      check("m_digit_2", bus.digit_2, m_d2);
      check("m_valid_1", bus.valid_1, m_v1);
      check("m_valid_2", bus.valid_2, m_v2);
      check("m_err_1",   bus.err_1, m_e1);
      check("m_err_2",   bus.err_2, m_e2);
      check("m_dp_1",    bus.dp_1, rst_n ? m_acc1[7] : 1'b0);
      check("m_dp_2",    bus.dp_2, rst_n ? m_acc2[7] : 1'b0);
      check("m_value",   bus.value, m_val);
      check("m_upd",     bus.upd, m_upd);
      check("m_err_cnt", bus.err_cnt, m_cnt);
    end
  end

  task automatic drive(input logic [8:0] s1, input logic [8:0] s2);
    @(negedge clk);
    bus.seg_led_1 = s1;
    bus.seg_led_2 = s2;
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.seg_led_1 = 9'h000;
    bus.seg_led_2 = 9'h000;
    edges(2);
    check("rst_digit_1", bus.digit_1, 4'hF);
    check("rst_digit_2", bus.digit_2, 4'hF);
    check("rst_value", bus.value, 0);
    check("rst_err_cnt", bus.err_cnt, 0);
    @(negedge clk) rst_n = 1'b1;
    edges(20);
    check("idle_digit_1", bus.digit_1, 4'hF);
    check("idle_upd", bus.upd, 0);

    // 37 after five edges, single upd pulse
    drive(9'h04F, 9'h007);
    edges(5);
    check("e4_digit_1", bus.digit_1, 4'hF);
    edges(1);
    check("e5_digit_1", bus.digit_1, 3);
    check("e5_digit_2", bus.digit_2, 7);
    check("e5_valid_1", bus.valid_1, 1);
    check("e5_value", bus.value, 37);
    check("e5_upd", bus.upd, 1);
    edges(1);
    check("e6_upd", bus.upd, 0);

    // Three-cycle glitch is rejected, four-cycle hold is taken
    drive(9'h04F, 9'h07F);
    edges(3);
    drive(9'h04F, 9'h007);
    edges(8);
    check("glitch_value", bus.value, 37);
    drive(9'h04F, 9'h07F);
    edges(6);
    check("hold_value", bus.value, 38);
    check("hold_upd", bus.upd, 1);

    // Illegal pattern, then simultaneous illegal accepts and saturation
    drive(9'h049, 9'h07F);
    edges(6);
    check("ill_digit_1", bus.digit_1, 4'hE);
    check("ill_err_1", bus.err_1, 1);
    check("ill_value", bus.value, 0);
    check("ill_err_cnt", bus.err_cnt, 1);
    for (int i = 0; i < 5; i++) begin
      drive(9'h04F, 9'h007);
      edges(6);
      drive(9'h049, 9'h049);
      edges(6);
      if (i == 0) check("dual_err_cnt", bus.err_cnt, 3);
    end
    check("sat_err_cnt", bus.err_cnt, 3);
    check("sat_err_2", bus.err_2, 1);

    // DP with zero, then DIG-off blank keeps DP
    drive(9'h0BF, 9'h007);
    edges(6);
    check("dp0_digit_1", bus.digit_1, 0);
    check("dp0_dp_1", bus.dp_1, 1);
    check("dp0_valid_1", bus.valid_1, 1);
    check("dp0_value", bus.value, 7);
    drive(9'h1BF, 9'h007);
    edges(6);
    check("blank_digit_1", bus.digit_1, 4'hF);
    check("blank_valid_1", bus.valid_1, 0);
    check("blank_err_1", bus.err_1, 0);
    check("blank_dp_1", bus.dp_1, 1);
    check("blank_value", bus.value, 0);

    // Reset two cycles into a candidate, pattern held through release
    drive(9'h066, 9'h007);
    edges(2);
    @(negedge clk) rst_n = 1'b0;
    edges(1);
    check("mid_rst_digit_2", bus.digit_2, 4'hF);
    check("mid_rst_dp_1", bus.dp_1, 0);
    check("mid_rst_err_cnt", bus.err_cnt, 0);
    @(negedge clk) rst_n = 1'b1;
    edges(5);
    check("rel5_digit_1", bus.digit_1, 4'hF);
    edges(1);
    check("rel6_digit_1", bus.digit_1, 4);
    check("rel6_value", bus.value, 47);
    check("rel6_upd", bus.upd, 1);

    edges(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seg_pattern_reader.md
Name: seg_pattern_reader

Overview:
- Reads back the two 9-bit seven-segment drive buses (MSB..LSB = DIG, DP, G, F, E, D, C, B, A) driving the two on-board digits.
- Converts each bus back to a BCD digit, plus DP and validity flags.
- Each channel has a stability filter, so only settled patterns are accepted.
- Combines both digits into a binary value for self-check/telemetry logic, pulses on every accepted change, and counts illegal patterns.

Parameters:
- STABLE_CYCLES, 4, consecutive clocks a pattern must hold before acceptance (legal range 1..255).
- ERR_W, 8, width of the saturating illegal-pattern counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- seg_led_1  input  9  segment bus of digit 1 (tens).
- seg_led_2  input  9  segment bus of digit 2 (units).
- digit_1  output  4  accepted BCD of channel 1.
- digit_2  output  4  accepted BCD of channel 2.
- valid_1  output  1  digit_1 holds a legal 0-9 code.
- valid_2  output  1  digit_2 holds a legal 0-9 code.
- dp_1  output  1  accepted DP bit, channel 1.
- dp_2  output  1  accepted DP bit, channel 2.
- err_1  output  1  accepted pattern on channel 1 is illegal.
- err_2  output  1  accepted pattern on channel 2 is illegal.
- value  output  7  digit_1*10+digit_2 (0..99) when both channels are valid, else 0.
- upd  output  1  one-cycle pulse when either channel accepts a new pattern.
- err_cnt  output  ERR_W  saturating count of illegal-pattern acceptances.

Behaviour:
- Reset (rst_n low at a rising edge):
  - Outputs: digit_* = 4'hF; valid_*, dp_*, err_*, value, upd and err_cnt all = 0.
  - Internal: input regs, candidates, counters = 0; accepted pattern per channel = 9'h000 (blank).
  - Reset asserted mid-filter discards the candidate; filtering restarts after release.
- Per-channel pipeline, channels independent and identical:
  - Stage 1: in_q <= seg_led_x every clock.
  - Filter: if in_q != cand then cand <= in_q and cnt <= 0; else cnt increments, saturating at STABLE_CYCLES-1.
  - Accept: when cnt == STABLE_CYCLES-1 and cand != acc, then on the next edge acc <= cand and the decoded outputs update.
- Latency: a new pattern first sampled at edge E0 and held unchanged updates outputs at edge E0+STABLE_CYCLES+1.
  - Default STABLE_CYCLES=4 gives 5 edges.
  - STABLE_CYCLES=1 gives 2 edges.
- Glitch rejection: any change before acceptance restarts the count. Re-presenting the already-accepted pattern never re-accepts and never pulses upd.
- Decode of an accepted pattern:
  - If DIG (bit 8) = 1: blank; digit=4'hF, valid=0, err=0.
  - Else bits[6:0] are matched against the table 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9.
  - 7'h00: blank; digit=4'hF, valid=0, err=0.
  - Any other unmatched code: illegal; digit=4'hE, valid=0, err=1.
  - dp_x = bit 7, independent of the digit decode; it is also updated for blank and illegal patterns.
- value:
  - Registered, computed from the post-update digits in the same edge as the channel update.
  - Formula tens*10+units, 7-bit result.
  - 0 whenever either valid is 0.
- upd: high for exactly one cycle at the accept edge. Simultaneous accepts on both channels give a single pulse.
- err_cnt:
  - +1 per channel acceptance of an illegal pattern.
  - Simultaneous illegal accepts on both channels give +2.
  - Saturates at 2^ERR_W-1; no wrap.
- No outputs are combinational from inputs.

Test Plan:
1. Reset with both buses 9'h000, release, hold for 20 clocks.
   - Expect all outputs at reset values and upd never high.
2. Drive seg_led_1=9'h04F and seg_led_2=9'h007 from edge E0.
   - At E0+5: digit_1=3, digit_2=7, valid_1=valid_2=1, value=37, upd=1 for one cycle.
   - From E0+6: upd=0.
3. With 37 accepted, glitch seg_led_2 to 9'h07F for 3 cycles, then restore 9'h007.
   - Expect no upd and value stays 37.
   - Then hold 9'h07F for 4 or more cycles: value=38, one upd pulse.
4. Drive seg_led_1=9'h049.
   - Expect digit_1=4'hE, err_1=1, value=0, err_cnt 0->1.
   - With ERR_W=2, repeat alternating illegal/legal patterns 5 times: err_cnt saturates at 3.
5. Drive seg_led_1=9'h0BF.
   - Expect digit_1=0, dp_1=1, valid_1=1.
   - Then 9'h1BF: blank; digit_1=4'hF, valid_1=0, err_1=0, dp_1=1, value=0.
6. Assert rst_n for one edge, 2 cycles into a new candidate; release with the pattern still held.
   - Expect reset values immediately.
   - Expect re-acceptance at release edge+STABLE_CYCLES+1.
